// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart transmitter between NREQ byte producers.
// Holds send long enough for the baud domain, then waits for a donetx rising edge or a timeout.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int CLK_FREQ  = 1000000,
    parameter int BAUD      = 9600,
    parameter int SEND_HOLD = CLK_FREQ / BAUD,
    parameter int TIMEOUT   = 16 * (CLK_FREQ / BAUD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*8-1:0]       data,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [7:0]              dintx,
    output logic                    send,
    input  logic                    donetx
);

    localparam int OWNER_W = $clog2(NREQ);
    localparam int CNT_MAX = (SEND_HOLD > TIMEOUT) ? SEND_HOLD : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(SEND_HOLD - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [NREQ-1:0]    ONE          = NREQ'(1);
    localparam logic [OWNER_W-1:0] LAST_IDX     = OWNER_W'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             donetx_prev_reg;

    logic [7:0]         data_arr [NREQ];
    logic [OWNER_W-1:0] winner;
    logic [OWNER_W-1:0] scan_idx;
    logic               found;
    logic               donetx_rise;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_data
            assign data_arr[gi] = data[8*gi +: 8];
        end
    endgenerate

    // Scan owner+1, owner+2, ... with wrap so the last owner has lowest priority.
    always_comb begin
        winner   = owner;
        found    = 1'b0;
        scan_idx = owner;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // A donetx level left over from before WAIT is not a completion.
    assign donetx_rise = donetx && !donetx_prev_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            donetx_prev_reg <= 1'b0;
            gnt             <= '0;
            done            <= '0;
            err             <= 1'b0;
            busy            <= 1'b0;
            owner           <= LAST_IDX;
            dintx           <= 8'h00;
            send            <= 1'b0;
        end else begin
            donetx_prev_reg <= donetx;
            gnt             <= '0;
            done            <= '0;
            err             <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (found) begin
                        owner     <= winner;
                        dintx     <= data_arr[winner];
                        gnt       <= ONE << winner;
                        send      <= 1'b1;
                        busy      <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (cnt_reg == HOLD_LAST) begin
                        send      <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= ST_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A completion on the final timeout cycle still counts as done.
                    if (donetx_rise) begin
                        done      <= ONE << owner;
                        busy      <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    send      <= 1'b0;
                    busy      <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
